// File: rtl/mux_arb_pkg.sv
// Shared defaults, output-stage state encoding and index helper for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned DEF_N_REQ = 4;
  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Modulo-n increment of a requester index
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first valid requester at or after rr_ptr, with wrap.
module rr_pick #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned SRC_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [SRC_W-1:0] rr_ptr,
  output logic             any_req,
  output logic [SRC_W-1:0] grant
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [SRC_W-1:0]   w_off;
  logic               w_found;
  int unsigned        w_sum;

  // Rotate so that rr_ptr lands at bit 0; the doubled copy supplies the wrapped bits
  assign w_dbl   = {req_valid, req_valid};
  assign w_rot   = N_REQ'(w_dbl >> rr_ptr);
  assign any_req = |req_valid;

  // Priority encoder: lowest set bit of the rotated vector is the offset from rr_ptr
  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_rot[i] && !w_found) begin
        w_off   = SRC_W'(i);
        w_found = 1'b1;
      end
    end
  end

  // Undo the rotation to recover the absolute requester index
  always_comb begin
    w_sum = 32'(rr_ptr) + 32'(w_off);
    grant = SRC_W'(w_sum % N_REQ);
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// N_REQ:1 registered mux with round-robin arbitration and valid/ready on both sides.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = DEF_N_REQ,
  parameter  int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned SRC_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SRC_W-1:0]       out_src,
  input  logic                   out_ready
);

  out_state_e       r_state;
  out_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [SRC_W-1:0] r_src;
  logic [SRC_W-1:0] r_ptr;

  logic             w_any_req;
  logic [SRC_W-1:0] w_grant;
  logic             w_can_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data_arr [N_REQ];
  logic [WIDTH-1:0] w_sel_data;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (r_ptr),
    .any_req   (w_any_req),
    .grant     (w_grant)
  );

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;

  // Output slot is free when empty or being drained this cycle; no grants while in reset
  assign w_can_accept = !out_valid || out_ready;
  assign w_xfer       = rst_n && w_can_accept && w_any_req;

  // Unpack the flat data bus and select the granted requester
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end
    w_sel_data = w_data_arr[w_grant];
  end

  // One-hot ready to the granted requester only
  always_comb begin
    req_ready = '0;
    if (w_xfer) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  // Output stage next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_xfer) w_state_nxt = ST_FULL;
      end
      ST_FULL: begin
        if (out_ready && !w_any_req) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Output stage state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture granted payload and advance the pointer past the winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_src  <= '0;
      r_ptr  <= '0;
    end else if (w_xfer) begin
      r_data <= w_sel_data;
      r_src  <= w_grant;
      r_ptr  <= SRC_W'(next_idx(32'(w_grant), N_REQ));
    end
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Shares one WIDTH-bit output channel, a registered N_REQ:1 mux, between N_REQ requesters using round-robin arbitration with valid/ready handshakes on both sides. It sits in front of a single shared consumer, such as a downstream mux or gate datapath, and sequences which source drives it each cycle. It is a single output register stage with a grant pointer and full throughput (one transfer per cycle).

Parameters:
N_REQ, 4, number of requesters (≥2).
WIDTH, 8, data width per requester.
SRC_W, $clog2(N_REQ), width of source index (derived, not overridden).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  N_REQ  per-requester valid.
req_data  input  N_REQ*WIDTH  flat vector; requester i at bits [i*WIDTH +: WIDTH].
req_ready  output  N_REQ  per-requester ready; at most one bit high.
out_valid  output  1  output holds a transfer.
out_data  output  WIDTH  granted data.
out_src  output  SRC_W  index of requester that produced out_data.
out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_src=0, rr_ptr=0. Any in-flight item is dropped. Outputs stay at reset values until the first clk edge after rst_n rises.
- Output stage states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = !out_valid || out_ready (combinational).
- Pick: g is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … N_REQ-1, 0, … rr_ptr-1 (modulo wrap). any_req = |req_valid.
- req_ready[g] = can_accept && any_req. All other req_ready bits are 0. There is a combinational path from out_ready and req_valid to req_ready; this path is intentional.
- Transfer on requester side: req_valid[g] && req_ready[g].
  - On that edge: out_data<=req_data[g], out_src<=g, out_valid<=1, rr_ptr<=(g+1) mod N_REQ.
- EMPTY→FULL: transfer occurs.
- FULL→FULL: out_ready=1 and a new transfer occurs in the same cycle (back-to-back, no bubble). Also FULL with out_ready=0: hold. out_data and out_src must stay stable while out_valid && !out_ready.
- FULL→EMPTY: out_ready=1 and !any_req.
- EMPTY with no request: stay EMPTY, rr_ptr unchanged.
- Latency: requester transfer at edge k → out_valid at k (registered output, visible after edge k).
- Fairness: a continuously valid requester is granted within N_REQ transfers.
- rr_ptr wraps N_REQ-1→0. It changes only on a transfer, never while stalled.
- Requesters must hold req_valid and req_data until ready. The block does not check this.

Decomposition:
- Shared package mux_arb_pkg: default N_REQ/WIDTH localparams; function next_idx(idx, n) for modulo increment.
- Sub-module rr_pick (purely combinational): inputs req_valid[N_REQ] and rr_ptr; outputs any_req and grant index g. It is implemented as a double-width rotate plus priority encoder. The top level holds the output register, rr_ptr, and the handshake logic.

Test Plan:
- Reset: drive rst_n=0 mid-transfer with out_valid=1 → out_valid=0, out_src=0, req_ready=0 immediately (asynchronous). After release, the first grant is to requester 0 if it is valid.
- All four valid, out_ready=1, data i=8'hA0+i → out_src sequence 0,1,2,3,0,… with out_data A0,A1,A2,A3,A0 on consecutive cycles, no bubbles.
- Only requester 2 valid, out_ready=1 → one transfer per cycle, out_src=2, rr_ptr toggles to 3 and the pick wraps back to 2.
- Backpressure: out_valid=1 with out_data=8'hA1, out_ready=0 for 3 cycles, requesters 0 and 3 valid → req_ready=0 throughout, out_data=A1 stable. When out_ready=1, the next grant goes to requester 3 (rr_ptr=2, scanning 2,3).
- Wrap: rr_ptr=3 and req_valid=4'b0011 → grant 0. Next, with req_valid=4'b0011, grant 1.
- Drain: FULL, out_ready=1, req_valid=0 → out_valid drops to 0 next cycle and rr_ptr is unchanged.
